player_hit_detector: RTL



---
 rtl/player_hit_detector_pkg.sv | 12 +
 rtl/player_hit_detector_overlap_counter.sv | 37 +++
 rtl/player_hit_detector.sv | 117 +++++++++++
 3 files changed

// File: rtl/player_hit_detector_pkg.sv
// Shared game package: missile count used by the missile generator and the
// hit detector, plus the hit-detector FSM state encoding.
package player_hit_detector_pkg;

    localparam int unsigned MISSILE_COUNT = 8;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        SCAN       = 1'b1
    } hit_state_e;

endpackage

// File: rtl/player_hit_detector_overlap_counter.sv
// Per-missile overlap pixel counter for one frame.
// Ports:
//   clk, resetN - clock, asynchronous active-low reset
//   count_en    - count overlap pixels this cycle
//   load        - frame boundary: restart the count with this cycle's pixel
//   ovl         - player and missile both opaque at the current pixel
//   count       - saturating overlap pixel count of the current frame
//   hit_c       - count has reached the hit threshold (combinational)
module player_hit_detector_overlap_counter #(
    parameter int unsigned OVERLAP_WIDTH      = 6,
    parameter int unsigned MIN_OVERLAP_PIXELS = 3
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     count_en,
    input  logic                     load,
    input  logic                     ovl,
    output logic [OVERLAP_WIDTH-1:0] count,
    output logic                     hit_c
);

    localparam logic [OVERLAP_WIDTH-1:0] COUNT_MAX = '1;

    // Boundary pixel belongs to the new frame; counting saturates, never wraps.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= OVERLAP_WIDTH'(ovl);
        end else if (count_en && ovl && (count != COUNT_MAX)) begin
            count <= count + OVERLAP_WIDTH'(1);
        end
    end

    assign hit_c = (count >= OVERLAP_WIDTH'(MIN_OVERLAP_PIXELS));

endmodule

// File: rtl/player_hit_detector.sv
// Player hit detector: counts player/missile overlap pixels per frame and, at
// each frame boundary, reports which missiles hit the player.
// Ports:
//   clk, resetN           - clock, asynchronous active-low reset
//   enable                - game running; low freezes all state
//   startOfFrame          - one-cycle frame boundary pulse
//   player_draw_request   - player pixel opaque
//   missile_draw_requests - per-missile pixel opaque
//   player_dead           - suppresses missile_collision
//   missile_collision     - one-cycle pulse: player hit in the previous frame
//   missile_hit           - one-cycle pulse vector of missiles that hit
//   hit_pixel_count       - saturated total overlap pixels of the previous frame
module player_hit_detector
    import player_hit_detector_pkg::*;
#(
    parameter int unsigned OVERLAP_WIDTH      = 6,
    parameter int unsigned MIN_OVERLAP_PIXELS = 3
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     enable,
    input  logic                     startOfFrame,
    input  logic                     player_draw_request,
    input  logic [MISSILE_COUNT-1:0] missile_draw_requests,
    input  logic                     player_dead,
    output logic                     missile_collision,
    output logic [MISSILE_COUNT-1:0] missile_hit,
    output logic [OVERLAP_WIDTH-1:0] hit_pixel_count
);

    localparam int unsigned SUM_W = OVERLAP_WIDTH + $clog2(MISSILE_COUNT);
    localparam logic [SUM_W-1:0] SUM_CLAMP = SUM_W'({OVERLAP_WIDTH{1'b1}});

    hit_state_e                 state;
    hit_state_e                 state_d;
    logic [MISSILE_COUNT-1:0]   ovl;
    logic [MISSILE_COUNT-1:0]   hit_vec;
    logic [OVERLAP_WIDTH-1:0]   counts [MISSILE_COUNT];
    logic                       count_en;
    logic                       load;
    logic [SUM_W-1:0]           overlap_sum;
    logic [OVERLAP_WIDTH-1:0]   sum_clamped;
    logic [MISSILE_COUNT-1:0]   missile_hit_d;
    logic                       missile_collision_d;
    logic [OVERLAP_WIDTH-1:0]   hit_pixel_count_d;

    assign ovl      = missile_draw_requests & {MISSILE_COUNT{player_draw_request}};
    // Draw requests are ignored until the first full frame starts.
    assign count_en = enable && (state == SCAN);
    assign load     = enable && startOfFrame;

    for (genvar i = 0; i < MISSILE_COUNT; i++) begin : g_counter
        player_hit_detector_overlap_counter #(
            .OVERLAP_WIDTH      (OVERLAP_WIDTH),
            .MIN_OVERLAP_PIXELS (MIN_OVERLAP_PIXELS)
        ) u_overlap_counter (
            .clk      (clk),
            .resetN   (resetN),
            .count_en (count_en),
            .load     (load),
            .ovl      (ovl[i]),
            .count    (counts[i]),
            .hit_c    (hit_vec[i])
        );
    end

    // Total overlap over all missiles, widened so the sum cannot wrap before clamping.
    always_comb begin
        overlap_sum = '0;
        for (int i = 0; i < MISSILE_COUNT; i++) begin
            overlap_sum = overlap_sum + SUM_W'(counts[i]);
        end
        sum_clamped = (overlap_sum > SUM_CLAMP) ? OVERLAP_WIDTH'(SUM_CLAMP)
                                                : OVERLAP_WIDTH'(overlap_sum);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state             <= WAIT_FRAME;
            missile_collision <= 1'b0;
            missile_hit       <= '0;
            hit_pixel_count   <= '0;
        end else begin
            state             <= state_d;
            missile_collision <= missile_collision_d;
            missile_hit       <= missile_hit_d;
            hit_pixel_count   <= hit_pixel_count_d;
        end
    end

    // Next state and evaluation at each enabled frame boundary while scanning.
    always_comb begin
        state_d             = state;
        missile_hit_d       = '0;
        missile_collision_d = 1'b0;
        hit_pixel_count_d   = hit_pixel_count;
        if (enable) begin
            case (state)
                WAIT_FRAME: begin
                    if (startOfFrame) begin
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (startOfFrame) begin
                        missile_hit_d       = hit_vec;
                        missile_collision_d = (|hit_vec) & ~player_dead;
                        hit_pixel_count_d   = sum_clamped;
                    end
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

endmodule
